bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- Two-requester round-robin arbiter for the shared snooping bus and L2 port between cpu1 and cpu2.
- Sits beside bus_controller and produces grant_core1/grant_core2 from req_core1/req_core2 and flush_in1/flush_in2.
- Sequences bus tenure: grant, hold, release, turnaround.
- Drives the owner select that muxes the granted core's address, data and opcode toward L2.

Parameters:
- TURNAROUND, 1, idle cycles with no grant between two tenures (0..7; 0 = release goes straight to IDLE).
- MAX_HOLD, 16, tenure limit in cycles, used only when BUS_ARB_TIMEOUT_EN is defined (2..255).
- HOLD_W, 8, width of the tenure counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_core1  in  1  core1 bus request; level, held for the whole transaction.
- req_core2  in  1  core2 bus request; level.
- flush_in1  in  1  core1 pipeline flush; aborts core1 tenure.
- flush_in2  in  1  core2 pipeline flush; aborts core2 tenure.
- grant_core1  out  1  core1 owns the bus.
- grant_core2  out  1  core2 owns the bus.
- bus_busy  out  1  a tenure is active (grant_core1 | grant_core2).
- bus_sel  out  1  owner select, 0 = core1, 1 = core2; holds the last owner when not busy.
- hold_cnt  out  HOLD_W  cycles elapsed in the current tenure; saturating.
- timeout_err  out  1  one-cycle pulse when a tenure is forcibly revoked.
- err_core  out  1  core revoked by the last timeout (0 = core1, 1 = core2); sticky.

Behaviour:
- All outputs are registered. Reset asserts asynchronously and immediately forces:
  - state = IDLE, all grants 0, bus_busy 0, hold_cnt 0, timeout_err 0, err_core 0.
  - bus_sel 1 and last_owner = core2, so core1 wins the first contention.
- States: IDLE, OWN1, OWN2, TURN.
- IDLE:
  - Only req_core1 sampled high (flush_in1 low) -> OWN1.
  - Only req_core2 sampled high (flush_in2 low) -> OWN2.
  - Both high -> the core that is not last_owner wins.
  - A request whose flush is high in the same cycle is ignored.
  - Grant is high from the edge after the request is sampled (1-cycle latency).
  - On entry to OWNx: last_owner <= x, bus_sel <= x, hold_cnt <= 0.
- OWNx:
  - grant_corex = 1, the other grant = 0.
  - hold_cnt increments each cycle and saturates at all-ones.
  - Release when req_corex is sampled low or flush_inx is sampled high.
  - On release: grant drops at the next edge and state goes to TURN, or to IDLE if TURNAROUND = 0.
  - The other core's requests and flushes are ignored while it waits.
- TURN:
  - No grant.
  - An internal counter runs TURNAROUND cycles, then state goes to IDLE.
  - Requests are re-evaluated in IDLE, never in TURN.
  - A continuously requesting core is therefore granted TURNAROUND+1 cycles after the previous release.
- Fairness:
  - With both cores requesting continuously, grants strictly alternate.
  - A releasing owner that re-requests immediately loses to a pending peer.
- Invariant: grant_core1 & grant_core2 is never 1, including across reset assertion and deassertion.
- Reset mid-tenure: grants drop asynchronously; after reset deassertion arbitration restarts from IDLE with core1 priority.

Optional Feature:
- Macro BUS_ARB_TIMEOUT_EN.
- Defined:
  - If hold_cnt reaches MAX_HOLD-1 while still in OWNx and no release condition is present, the grant is revoked at the next edge and state goes to TURN.
  - timeout_err pulses high for exactly that one cycle; err_core <= x.
  - last_owner = x, so the peer wins the next contention.
  - A tenure that releases normally in the same cycle counts as a normal release: no error.
- Not defined:
  - timeout_err is tied 0 and err_core holds its reset value of 0.
  - Tenure is unbounded.
  - The ports are still present.

Test Plan:
- Reset, then req_core1=1 only, held 5 cycles then dropped -> grant_core1 high from cycle 1 for 5 cycles, bus_sel=0, hold_cnt counts 0..4; TURN 1 cycle; grant_core2 stays 0 throughout.
- req_core1 and req_core2 raised in the same cycle from reset, both held, each owner drops req for 1 cycle after 3 cycles of grant -> grant order core1, core2, core1, core2; bus_sel toggles; never both grants high.
- core2 owns the bus, flush_in2 pulses 1 cycle while req_core2 stays high and req_core1 is pending -> grant_core2 falls next edge; grant_core1 rises 2 cycles later (TURNAROUND=1).
- TURNAROUND=0, core1 releases while core2 is requesting -> grant_core2 rises the cycle after grant_core1 falls; never overlaps.
- BUS_ARB_TIMEOUT_EN, MAX_HOLD=4, core1 holds req indefinitely with core2 requesting -> grant_core1 high exactly 4 cycles; timeout_err pulses 1 cycle; err_core=0; core2 granted after TURN. Without the macro: core1 keeps the grant and timeout_err stays 0.
- reset asserted mid-tenure with both requests high, released 3 cycles later -> grants 0 asynchronously; first grant after release goes to core1, latency 1.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_rr
// Description : Two-requester round-robin arbiter for the shared snooping bus
//               and L2 port. Sequences tenure as grant -> hold -> release ->
//               turnaround. Drives the owner select for the L2 address/data
//               mux.
//               Optional tenure timeout enabled by macro BUS_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr #(
    parameter int TURNAROUND = 1,   // idle cycles between tenures (0..7)
    parameter int MAX_HOLD   = 16,  // tenure limit with timeout enabled (2..255)
    parameter int HOLD_W     = 8    // tenure counter width, 2^HOLD_W > MAX_HOLD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_core1,
    input  logic              req_core2,
    input  logic              flush_in1,
    input  logic              flush_in2,
    output logic              grant_core1,
    output logic              grant_core2,
    output logic              bus_busy,
    output logic              bus_sel,
    output logic [HOLD_W-1:0] hold_cnt,
    output logic              timeout_err,
    output logic              err_core
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN1 = 2'd1,
        OWN2 = 2'd2,
        TURN = 2'd3
    } state_t;

    // Turnaround length 0 skips TURN entirely, so release lands in IDLE.
    localparam logic [2:0] c_TURN_LAST = (TURNAROUND == 0) ? 3'd0 : 3'(TURNAROUND - 1);
    localparam state_t     c_AFTER_REL = (TURNAROUND == 0) ? IDLE : TURN;

    // Reject illegal parameter combinations at elaboration.
    generate
        if (TURNAROUND < 0 || TURNAROUND > 7 || MAX_HOLD < 2 || MAX_HOLD > 255 ||
            (MAX_HOLD >> HOLD_W) != 0) begin : g_param_check
            $error("bus_arbiter_rr: illegal parameter combination");
        end
    endgenerate

    state_t              state_q, state_d;
    logic                grant1_q, grant1_d;
    logic                grant2_q, grant2_d;
    logic                busy_q, busy_d;
    // last_owner doubles as the bus select: both change only on tenure entry.
    logic                last_owner_q, last_owner_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [2:0]          turn_cnt_q, turn_cnt_d;
    logic                timeout_err_q, timeout_err_d;
    logic                err_core_q, err_core_d;

    logic                w_cand1;
    logic                w_cand2;
    logic                w_own_req;
    logic                w_own_flush;
    logic                w_timeout;

    // A request with a same-cycle flush does not compete.
    assign w_cand1     = req_core1 & ~flush_in1;
    assign w_cand2     = req_core2 & ~flush_in2;
    // In OWNx the current owner is last_owner; only its inputs matter.
    assign w_own_req   = last_owner_q ? req_core2 : req_core1;
    assign w_own_flush = last_owner_q ? flush_in2 : flush_in1;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    assign w_timeout = (hold_cnt_q == c_HOLD_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and next-output computation for the tenure sequencer.
    always_comb begin
        state_d       = state_q;
        last_owner_d  = last_owner_q;
        hold_cnt_d    = hold_cnt_q;
        turn_cnt_d    = turn_cnt_q;
        timeout_err_d = 1'b0;
        err_core_d    = err_core_q;
        case (state_q)
            IDLE: begin
                // Tie goes to the core that did not own the bus last.
                if (w_cand1 && (!w_cand2 || last_owner_q)) begin
                    state_d      = OWN1;
                    last_owner_d = 1'b0;
                    hold_cnt_d   = '0;
                end else if (w_cand2) begin
                    state_d      = OWN2;
                    last_owner_d = 1'b1;
                    hold_cnt_d   = '0;
                end
            end
            OWN1, OWN2: begin
                if (!w_own_req || w_own_flush) begin
                    state_d    = c_AFTER_REL;
                    turn_cnt_d = c_TURN_LAST;
                end else if (w_timeout) begin
                    state_d       = c_AFTER_REL;
                    turn_cnt_d    = c_TURN_LAST;
                    timeout_err_d = 1'b1;
                    err_core_d    = last_owner_q;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            TURN: begin
                if (turn_cnt_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    turn_cnt_d = turn_cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        grant1_d = (state_d == OWN1);
        grant2_d = (state_d == OWN2);
        busy_d   = grant1_d | grant2_d;
    end

    // State and registered outputs; reset favours core1 on first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant1_q      <= 1'b0;
            grant2_q      <= 1'b0;
            busy_q        <= 1'b0;
            last_owner_q  <= 1'b1;
            hold_cnt_q    <= '0;
            turn_cnt_q    <= 3'd0;
            timeout_err_q <= 1'b0;
            err_core_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant1_q      <= grant1_d;
            grant2_q      <= grant2_d;
            busy_q        <= busy_d;
            last_owner_q  <= last_owner_d;
            hold_cnt_q    <= hold_cnt_d;
            turn_cnt_q    <= turn_cnt_d;
            timeout_err_q <= timeout_err_d;
            err_core_q    <= err_core_d;
        end
    end

    assign grant_core1 = grant1_q;
    assign grant_core2 = grant2_q;
    assign bus_busy    = busy_q;
    assign bus_sel     = last_owner_q;
    assign hold_cnt    = hold_cnt_q;
    assign timeout_err = timeout_err_q;
    assign err_core    = err_core_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter_rr
// Description : Bench for bus_arbiter_rr. Two instances (turnaround 1 and 0)
//               share directed and random stimulus and are compared every
//               cycle against a tenure-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_rr;

    localparam int TA_A = 1;
    localparam int TA_B = 0;
    localparam int MH_A = 16;
    localparam int MH_B = 4;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       req_core1, req_core2, flush_in1, flush_in2;
    logic       g1_a, g2_a, busy_a, sel_a, terr_a, ecore_a;
    logic       g1_b, g2_b, busy_b, sel_b, terr_b, ecore_b;
    logic [7:0] hold_a, hold_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state per instance: owner 0=none, 1=core1, 2=core2.
    int m_owner[2];
    int m_age[2];
    int m_gap[2];
    int m_last[2];
    int m_terr[2];
    int m_ecore[2];
    int ta[2];
    int mh[2];

    always #5 clk = ~clk;

    bus_arbiter_rr #(.TURNAROUND(TA_A), .MAX_HOLD(MH_A), .HOLD_W(8)) dut_a (
        .clk(clk), .reset(reset),
        .req_core1(req_core1), .req_core2(req_core2),
        .flush_in1(flush_in1), .flush_in2(flush_in2),
        .grant_core1(g1_a), .grant_core2(g2_a), .bus_busy(busy_a),
        .bus_sel(sel_a), .hold_cnt(hold_a),
        .timeout_err(terr_a), .err_core(ecore_a)
    );

    bus_arbiter_rr #(.TURNAROUND(TA_B), .MAX_HOLD(MH_B), .HOLD_W(8)) dut_b (
        .clk(clk), .reset(reset),
        .req_core1(req_core1), .req_core2(req_core2),
        .flush_in1(flush_in1), .flush_in2(flush_in2),
        .grant_core1(g1_b), .grant_core2(g2_b), .bus_busy(busy_b),
        .bus_sel(sel_b), .hold_cnt(hold_b),
        .timeout_err(terr_b), .err_core(ecore_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic string tg(input string s, input int i);
        return $sformatf("%s[%0d]@%0t", s, i, $time);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = 0;
            m_age[i]   = 0;
            m_gap[i]   = 0;
            m_last[i]  = 2;
            m_terr[i]  = 0;
            m_ecore[i] = 0;
        end
    endtask

    // One clock of the tenure rules: owner keeps bus until it drops/flushes
    // (or hits the hold limit), then the bus idles ta cycles before arbitration.
    task automatic model_step(input int i);
        bit rq, fl, rel, tmo, c1, c2;
        int w;
        m_terr[i] = 0;
        if (m_owner[i] != 0) begin
            rq  = (m_owner[i] == 1) ? req_core1 : req_core2;
            fl  = (m_owner[i] == 1) ? flush_in1 : flush_in2;
            rel = !rq || fl;
            tmo = TO_EN && !rel && (m_age[i] == mh[i] - 1);
            if (rel || tmo) begin
                if (tmo) begin
                    m_terr[i]  = 1;
                    m_ecore[i] = m_owner[i] - 1;
                end
                m_owner[i] = 0;
                m_gap[i]   = ta[i];
            end else if (m_age[i] < 255) begin
                m_age[i]++;
            end
        end else if (m_gap[i] > 0) begin
            m_gap[i]--;
        end else begin
            c1 = req_core1 && !flush_in1;
            c2 = req_core2 && !flush_in2;
            w  = 0;
            if (c1 && c2)  w = (m_last[i] == 1) ? 2 : 1;
            else if (c1)   w = 1;
            else if (c2)   w = 2;
            if (w != 0) begin
                m_owner[i] = w;
                m_last[i]  = w;
                m_age[i]   = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic g1, g2, bz, sl, te, ec;
        logic [7:0] hc;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) {g1, g2, bz, sl, te, ec, hc} = {g1_a, g2_a, busy_a, sel_a, terr_a, ecore_a, hold_a};
            else        {g1, g2, bz, sl, te, ec, hc} = {g1_b, g2_b, busy_b, sel_b, terr_b, ecore_b, hold_b};
            check_eq(tg("grant1", i), 32'(g1), 32'(m_owner[i] == 1));
            check_eq(tg("grant2", i), 32'(g2), 32'(m_owner[i] == 2));
            check_eq(tg("busy", i), 32'(bz), 32'(m_owner[i] != 0));
            check_eq(tg("bus_sel", i), 32'(sl), 32'(m_last[i] - 1));
            check_eq(tg("timeout_err", i), 32'(te), 32'(m_terr[i]));
            check_eq(tg("err_core", i), 32'(ec), 32'(m_ecore[i]));
            check_eq(tg("grant_excl", i), 32'(g1 & g2), 32'd0);
            if (m_owner[i] != 0) check_eq(tg("hold_cnt", i), 32'(hc), 32'(m_age[i]));
        end
    endtask

    // Advance one clock, update the model from the sampled inputs, then check.
    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
        #1;
        compare_all();
    endtask

    task automatic drive(input bit r1, input bit r2, input bit f1, input bit f2, input int n);
        req_core1 = r1;
        req_core2 = r2;
        flush_in1 = f1;
        flush_in2 = f2;
        repeat (n) cycle();
    endtask

    initial begin
        ta[0] = TA_A; ta[1] = TA_B;
        mh[0] = MH_A; mh[1] = MH_B;
        model_reset();
        reset = 1'b1;
        req_core1 = 1'b0; req_core2 = 1'b0; flush_in1 = 1'b0; flush_in2 = 1'b0;
        repeat (2) cycle();
        check_eq("reset_bus_sel", 32'(sel_a), 32'd1);
        check_eq("reset_hold_cnt", 32'(hold_a), 32'd0);
        reset = 1'b0;

        // Single requester: 5-cycle tenure then release.
        drive(1, 0, 0, 0, 5);
        drive(0, 0, 0, 0, 4);

        // Both requesting: owner drops for one cycle after 3 cycles of grant.
        for (int k = 0; k < 8; k++) begin
            drive(1, 1, 0, 0, 3);
            if (m_owner[0] == 1)      drive(0, 1, 0, 0, 1);
            else if (m_owner[0] == 2) drive(1, 0, 0, 0, 1);
            else                      drive(1, 1, 0, 0, 1);
        end
        drive(0, 0, 0, 0, 4);

        // core2 owns, flush_in2 pulses while core1 waits.
        drive(0, 1, 0, 0, 3);
        drive(1, 1, 0, 1, 1);
        drive(1, 1, 0, 0, 6);
        drive(0, 0, 0, 0, 3);

        // Long contention (timeouts if enabled) and single-owner saturation.
        drive(1, 1, 0, 0, 40);
        drive(0, 0, 0, 0, 3);
        drive(1, 0, 0, 0, 300);
        drive(0, 0, 0, 0, 3);

        // Reset mid-tenure: grants must drop before the next edge.
        drive(0, 1, 0, 0, 3);
        drive(1, 1, 0, 0, 3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("async_rst_g1", 32'(g1_a | g1_b), 32'd0);
        check_eq("async_rst_g2", 32'(g2_a | g2_b), 32'd0);
        drive(1, 1, 0, 0, 3);
        reset = 1'b0;
        drive(1, 1, 0, 0, 1);
        check_eq("first_after_reset_a", 32'(g1_a), 32'd1);
        check_eq("first_after_reset_b", 32'(g1_b), 32'd1);
        drive(0, 0, 0, 0, 3);

        // Random phase: sticky requests, sparse flushes and resets.
        for (int c = 0; c < 3000; c++) begin
            bit r1, r2, f1, f2;
            r1 = req_core1; r2 = req_core2;
            if ($urandom_range(0, 7) == 0) r1 = !r1;
            if ($urandom_range(0, 7) == 0) r2 = !r2;
            f1 = ($urandom_range(0, 29) == 0);
            f2 = ($urandom_range(0, 29) == 0);
            reset = (!reset && $urandom_range(0, 499) == 0);
            drive(r1, r2, f1, f2, 1);
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
